pk_stream_packer: RTL
=====================

Name: pk_stream_packer

Overview:
- Streams the Dilithium public key (rho || packed t1) as OUT_W-bit words over a valid/ready interface, instead of building one flat bus.
- Parameter set (K = 4/6/8) is chosen at run time.
- Sits between the KeyGen t1 producer and the downstream consumer (hash/SHAKE input or key-store writer).
- Applies backpressure to the t1 producer and signals frame completion.

Parameters:
- OUT_W, 64: output word width. Power of two, 8..256. Divides 256 and 2560.
- COEF_W, 10: t1 coefficient width.
- RHO_W, 256: rho width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches rho and mode
- mode  in  2  0: K=4, 1: K=6, 2: K=8, 3: reserved
- rho  in  RHO_W  seed; sampled only on accepted start
- t1_valid  in  1  coefficient valid
- t1_data  in  COEF_W  coefficient
- t1_ready  out  1  coefficient accepted when t1_valid && t1_ready
- out_valid  out  1  output word valid
- out_data  out  OUT_W  output word
- out_ready  in  1  consumer ready
- out_last  out  1  marks final word of frame (qualified by out_valid)
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after final word handshake
- err  out  1  sticky error flag; tied 0 unless PKP_ERR_EN

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All outputs 0. State IDLE. Accumulator, counters and latched rho/mode cleared. Reset mid-frame aborts the frame with no done.
- Stream layout: stream bit b goes to word b/OUT_W, bit b%OUT_W.
  - Bits [255:0] carry rho, bit 0 first.
  - t1 coefficient j occupies stream bits [256+j*COEF_W +: COEF_W].
  - Total bits: 256 + K*256*COEF_W. Word count: 164 / 244 / 324 for OUT_W=64.
- Accepted start: start && state==IDLE && mode!=3. Latches rho, K and word/coefficient counters; enters RHO.
  - start while busy: ignored.
  - mode==3: ignored; busy stays 0.
- RHO state:
  - out_valid=1 from the cycle after start.
  - out_data = rho[w*OUT_W +: OUT_W]. w advances on each out handshake.
  - t1_ready=0.
  - After RHO_W/OUT_W handshakes, enter T1.
- T1 state:
  - Bit accumulator acc, width OUT_W+COEF_W, with fill count acc_cnt.
  - t1_ready = (coef_rem != 0) && (acc_cnt < OUT_W).
  - Accepted coefficient is written at acc[acc_cnt +: COEF_W]; acc_cnt += COEF_W; coef_rem decrements.
  - out_valid = (acc_cnt >= OUT_W); out_data = acc[OUT_W-1:0].
  - On out handshake: acc >>= OUT_W; acc_cnt -= OUT_W.
  - Coefficient accept and word output are mutually exclusive by construction; no same-cycle merge is needed.
  - No padding: frame length is an exact multiple of OUT_W.
- out_data, out_valid and out_last hold stable while out_valid && !out_ready.
- out_last=1 on the final word: last t1 word, identified by word counter == total-1.
- Final handshake: next cycle done=1 for one cycle, busy=0, state IDLE.
  - A new start is accepted in the done cycle or later.
- busy=1 from the cycle after an accepted start until the final handshake cycle, inclusive.
- t1_valid in IDLE/RHO: ignored, no handshake. Producer must hold data per valid/ready rules.

Optional Feature:
- Macro: PKP_ERR_EN.
- Defined: err is set and sticky on any of:
  - start while busy
  - start with mode==3
  - t1_valid while state==IDLE
  - err is cleared on the next accepted start.
- Undefined: err is constant 0 and no error logic is synthesised. Datapath behaviour is identical in both builds.

Test Plan:
- Mode 0, OUT_W=64, rho=0x00..1F byte pattern, t1_data[j]=j mod 1024, out_ready=1 -> 164 words.
  - Word0 = 0x0706050403020100.
  - Word4 = 0x6014_0400_C020_0400.
  - out_last on word 163; done pulses one cycle after it; busy falls.
- Mode 2, random t1, out_ready random 50% -> 324 words. Concatenation matches the reference model flat layout (20736 bits). out_data stable during every stall.
- Mode 1, t1_valid random gaps -> 244 words; t1_ready never high in RHO or once 1536 coefficients are consumed.
- start pulsed mid-frame (mode 1) and mode=3 start in IDLE -> frame unaffected; busy stays 0 for the mode-3 case. With PKP_ERR_EN, err=1 in both cases, cleared by the next valid start.
- rst_n asserted at word 100 of a mode 0 frame -> all outputs 0 immediately; a new start then produces a correct full 164-word frame.
- Back-to-back frames: start issued in the done cycle -> second frame's word0 valid on the following cycle, with correct rho.

Source files
------------

// File: rtl/pk_stream_packer.sv
// Streams the Dilithium public key (rho || packed t1) as OUT_W-bit words over valid/ready.
// Optional sticky protocol-error flag is built only when PKP_ERR_EN is defined.
module pk_stream_packer #(
    parameter int OUT_W  = 64,
    parameter int COEF_W = 10,
    parameter int RHO_W  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [RHO_W-1:0]  rho,
    input  logic              t1_valid,
    input  logic [COEF_W-1:0] t1_data,
    output logic              t1_ready,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_data,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int RHO_WORDS  = RHO_W / OUT_W;
    localparam int T1_WORDS_K = 256 * COEF_W / OUT_W;
    localparam int WCNT_W     = $clog2(RHO_WORDS + 8 * T1_WORDS_K + 1);
    localparam int CREM_W     = $clog2(8 * 256 + 1);
    localparam int ACC_W      = OUT_W + COEF_W;
    localparam int ACNT_W     = $clog2(ACC_W + 1);

    localparam logic [WCNT_W-1:0] RHO_LAST = WCNT_W'(RHO_WORDS - 1);
    localparam logic [WCNT_W-1:0] LAST_K4  = WCNT_W'(RHO_WORDS + 4 * T1_WORDS_K - 1);
    localparam logic [WCNT_W-1:0] LAST_K6  = WCNT_W'(RHO_WORDS + 6 * T1_WORDS_K - 1);
    localparam logic [WCNT_W-1:0] LAST_K8  = WCNT_W'(RHO_WORDS + 8 * T1_WORDS_K - 1);
    localparam logic [CREM_W-1:0] COEFS_K4 = CREM_W'(4 * 256);
    localparam logic [CREM_W-1:0] COEFS_K6 = CREM_W'(6 * 256);
    localparam logic [CREM_W-1:0] COEFS_K8 = CREM_W'(8 * 256);
    localparam logic [ACNT_W-1:0] OUT_W_C  = ACNT_W'(OUT_W);
    localparam logic [ACNT_W-1:0] COEF_W_C = ACNT_W'(COEF_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RHO  = 2'd1,
        T1   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                done_q, done_d;
    logic [RHO_W-1:0]    rho_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ACNT_W-1:0]   acc_cnt_q;
    logic [CREM_W-1:0]   coef_rem_q;
    logic [WCNT_W-1:0]   wcnt_q;
    logic [WCNT_W-1:0]   wlast_q;
    logic [WCNT_W-1:0]   wlast_sel;
    logic [CREM_W-1:0]   coefs_sel;
    logic                start_acc;
    logic                out_hs;
    logic                t1_hs;

    assign start_acc = start && (state_q == IDLE) && (mode != 2'd3);
    assign out_hs    = out_valid && out_ready;
    assign t1_hs     = t1_valid && t1_ready;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    always_comb begin
        wlast_sel = LAST_K4;
        coefs_sel = COEFS_K4;
        case (mode)
            2'd1: begin
                wlast_sel = LAST_K6;
                coefs_sel = COEFS_K6;
            end
            2'd2: begin
                wlast_sel = LAST_K8;
                coefs_sel = COEFS_K8;
            end
            default: ;
        endcase
    end

    // Output/handshake decode and next state
    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        t1_ready  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_acc) state_d = RHO;
            end
            RHO: begin
                out_valid = 1'b1;
                out_data  = rho_q[OUT_W-1:0];
                if (out_ready && (wcnt_q == RHO_LAST)) state_d = T1;
            end
            T1: begin
                out_valid = (acc_cnt_q >= OUT_W_C);
                out_data  = acc_q[OUT_W-1:0];
                out_last  = out_valid && (wcnt_q == wlast_q);
                t1_ready  = (coef_rem_q != '0) && (acc_cnt_q < OUT_W_C);
                if (out_valid && out_ready && out_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Datapath: rho shifter, t1 bit accumulator, word/coefficient counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rho_q      <= '0;
            acc_q      <= '0;
            acc_cnt_q  <= '0;
            coef_rem_q <= '0;
            wcnt_q     <= '0;
            wlast_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_acc) begin
                        rho_q      <= rho;
                        acc_q      <= '0;
                        acc_cnt_q  <= '0;
                        coef_rem_q <= coefs_sel;
                        wcnt_q     <= '0;
                        wlast_q    <= wlast_sel;
                    end
                end
                RHO: begin
                    if (out_hs) begin
                        rho_q  <= rho_q >> OUT_W;
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                T1: begin
                    // t1_ready and out_valid are disjoint on acc_cnt, so at most one fires
                    if (t1_hs) begin
                        acc_q      <= acc_q | (ACC_W'(t1_data) << acc_cnt_q);
                        acc_cnt_q  <= acc_cnt_q + COEF_W_C;
                        coef_rem_q <= coef_rem_q - 1'b1;
                    end else if (out_hs) begin
                        acc_q     <= acc_q >> OUT_W;
                        acc_cnt_q <= acc_cnt_q - OUT_W_C;
                        wcnt_q    <= wcnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PKP_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (start_acc) begin
            err_q <= 1'b0;
        end else if ((start && (state_q != IDLE)) || (start && (mode == 2'd3)) ||
                     (t1_valid && (state_q == IDLE))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
